// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write packer and read unpacker.
// FIFO word layout: {last, nlanes_m1[CNT_W-1:0], data[IN_W*RATIO-1:0]}.
package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } wr_state_e;

  localparam int DATA_LSB = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

  function automatic int out_w(input int in_w, input int ratio);
    return 1 + cnt_w(ratio) + in_w * ratio;
  endfunction

  function automatic int cnt_lsb(input int in_w, input int ratio);
    return DATA_LSB + in_w * ratio;
  endfunction

  function automatic int last_bit(input int in_w, input int ratio);
    return out_w(in_w, ratio) - 1;
  endfunction

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats into one wide FIFO word carrying last + lane count.
// Holds one pending word; never writes while the FIFO reports full.
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int PKT_CNT_W = 16,
  localparam int CNT_W    = cnt_w(RATIO),
  localparam int OUT_W    = out_w(IN_W, RATIO)
) (
  input  logic                 wr_clk_i,
  input  logic                 wr_rst_ni,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [IN_W-1:0]      s_data_i,
  input  logic                 s_last_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_wr_en_o,
  output logic [OUT_W-1:0]     fifo_wr_data_o,
  output logic [PKT_CNT_W-1:0] pkt_cnt_o,
  output logic                 busy_o
);

  localparam int DATA_W = IN_W * RATIO;
  localparam int LAST_B = last_bit(IN_W, RATIO);

  wr_state_e              state_q, state_d;
  logic [CNT_W-1:0]       lane_q, lane_d;
  logic [DATA_W-1:0]      acc_q, acc_d;
  logic [OUT_W-1:0]       out_q, out_d;
  logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0]      merged;
  logic                   out_valid, accept, complete, wr_en;

  assign out_valid = (state_q == PEND);
  // Ready depends only on registered state and full, never on s_valid_i.
  assign s_ready_o = ~(out_valid & fifo_full_i);
  assign accept    = s_valid_i & s_ready_o;
  assign complete  = accept & ((lane_q == CNT_W'(RATIO - 1)) | s_last_i);
  assign wr_en     = out_valid & ~fifo_full_i;

  always_comb begin
    merged = acc_q;
    merged[int'(lane_q) * IN_W +: IN_W] = s_data_i;
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    out_d     = out_q;
    pkt_cnt_d = pkt_cnt_q;
    if (complete) begin
      out_d  = {s_last_i, lane_q, merged};
      acc_d  = '0;
      lane_d = '0;
    end else if (accept) begin
      acc_d  = merged;
      lane_d = lane_q + CNT_W'(1);
    end
    unique case (state_q)
      FILL:    if (complete) state_d = PEND;
      PEND:    if (wr_en && !complete) state_d = FILL;
      default: state_d = FILL;
    endcase
    if (wr_en && out_q[LAST_B]) pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
  end

  always_ff @(posedge wr_clk_i or negedge wr_rst_ni) begin
    if (!wr_rst_ni) begin
      state_q   <= FILL;
      lane_q    <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign fifo_wr_en_o   = wr_en;
  assign fifo_wr_data_o = out_q;
  assign pkt_cnt_o      = pkt_cnt_q;
  assign busy_o         = out_valid | (lane_q != '0);

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-domain stage that sits directly upstream of the dual-clock FIFO. It accepts a narrow valid/ready byte stream with packet framing and packs RATIO input beats into one wide FIFO word. Each word carries a last flag and a lane count. Backpressure comes from the FIFO full flag, and the block never issues a write while full, so FIFO overflow cannot occur.

Parameters:
IN_W, 8, input beat width in bits
RATIO, 4, input beats per FIFO word; must be ≥1
CNT_W, derived = max(1, clog2(RATIO)), width of the lane-count field
OUT_W, derived = 1 + CNT_W + IN_W*RATIO, FIFO word width (the FIFO DATA_W must equal this)
PKT_CNT_W, 16, width of the packet counter

Ports:
wr_clk_i  in  1  write-domain clock
wr_rst_ni  in  1  reset, asynchronous, active-low
s_valid_i  in  1  input beat valid
s_ready_o  out  1  input beat ready
s_data_i  in  IN_W  input beat data
s_last_i  in  1  final beat of packet
fifo_full_i  in  1  FIFO full flag (write domain)
fifo_wr_en_o  out  1  FIFO write enable
fifo_wr_data_o  out  OUT_W  {last, nlanes_m1[CNT_W-1:0], data[IN_W*RATIO-1:0]}
pkt_cnt_o  out  PKT_CNT_W  count of packets fully written to FIFO
busy_o  out  1  partial word in accumulator or word pending

Behaviour:
- Reset (async assert, sync release):
  - acc, lane index, out_valid and pkt_cnt_o clear to 0.
  - fifo_wr_en_o = 0, fifo_wr_data_o = 0, s_ready_o = 1 after reset, busy_o = 0.
- Beat accepted when s_valid_i & s_ready_o.
  - s_ready_o = ~(out_valid & fifo_full_i). This is combinational from registered state plus full; there is no path from s_valid_i.
- Lane order:
  - Beat k of a word lands in data[k*IN_W +: IN_W], so lane 0 sits in the LSBs.
  - Lane index increments per accepted beat.
- Word completion: an accepted beat completes a word when lane index == RATIO-1 or s_last_i = 1.
  - On completion, the output register loads {s_last_i, lane index, acc merged with the current beat}.
  - Unused upper lanes are zero.
  - out_valid is set and the lane index returns to 0. The accumulator is zeroed on the same edge.
- Output:
  - fifo_wr_en_o = out_valid & ~fifo_full_i (combinational).
  - fifo_wr_data_o is registered and stable while out_valid = 1.
  - out_valid clears on the edge where fifo_wr_en_o = 1, unless a new word completes on that same edge; in that case the new word loads and out_valid stays 1.
- Throughput: with fifo_full_i low, sustained one beat per cycle gives one write per RATIO cycles with zero input stalls, including RATIO = 1 (one write per cycle).
- Latency: the completing beat is accepted at edge N, and fifo_wr_en_o is high in cycle N+1 if not full.
- Full: while out_valid & fifo_full_i, s_ready_o = 0 and the accumulator is frozen. The pending word is held unchanged until full drops.
- FSM, 2 states:
  - FILL (out_valid = 0).
  - PEND (out_valid = 1).
  - FILL→PEND on completion.
  - PEND→FILL on a write with no simultaneous completion.
  - PEND→PEND on a write with a simultaneous completion, or on full.
- pkt_cnt_o increments by 1 on each FIFO write whose last bit = 1. It wraps modulo 2^PKT_CNT_W.
- busy_o = out_valid | (lane index != 0).
- Reset mid-packet discards the partial word and any pending word; no write is issued.
- A last on lane 0 produces a one-lane word with nlanes_m1 = 0.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function.
  - Derived OUT_W/CNT_W formulas.
  - Field offsets LAST_BIT, CNT_LSB, DATA_LSB, reused by the read-side unpacker.
- No sub-module; the block is a single RTL file.

Test Plan:
- RATIO=4, beats 0x11,0x22,0x33,0x44 with no last and full=0 → one write with data 0x44332211, last=0, nlanes_m1=3; pkt_cnt_o=0.
- Beats 0x11,0x22 with last on 0x22 → data 0x00002211, last=1, nlanes_m1=1; pkt_cnt_o 0→1 one cycle after the write.
- 16 back-to-back beats, full=0 → s_ready_o constantly 1; 4 writes spaced 4 cycles apart, first in the cycle after beat 4.
- Word pending with full held high for 10 cycles → fifo_wr_en_o=0, s_ready_o=0, data stable. Drop full → write in that cycle; s_ready_o=1 in the same cycle.
- Assert wr_rst_ni low after 2 beats → outputs clear immediately; after release, 4 beats 0xA0..0xA3 → 0xA3A2A1A0, with no stale lanes.
- RATIO=1, continuous 8 beats, with full pulsed for 1 cycle at beat 4 → exactly 8 writes in order; no write while full=1.
